text_console_renderer: RTL and testbench

- Sits directly downstream of the VGA sync timing generator and consumes its x, y, video_on and registered hsync/vsync.
- Holds an 80x30 character buffer that the Morse decoder writes into through a valid/ready character stream.
- Renders the buffer with an 8x16 font into 12-bit RGB, and delays hsync/vsync to stay aligned with the pixel pipeline.
- Owns cursor management, line wrap, backspace, and a full-screen clear sequencer.

---
 rtl/morse_vga_pkg.sv | 24 ++
 rtl/font_rom.sv | 11 +
 rtl/text_console_renderer.sv | 127 ++++++++++++
 tb/tb_text_console_renderer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_vga_pkg.sv
// morse_vga_pkg: text console geometry, control codes, write FSM states and glyph table
package morse_vga_pkg;
    localparam int TEXT_COLS = 80;
    localparam int TEXT_ROWS = 30;
    localparam int FONT_W    = 8;
    localparam int FONT_H    = 16;
    localparam int BUF_DEPTH = TEXT_COLS * TEXT_ROWS;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_TILDE = 8'h7E;

    typedef enum logic [1:0] {IDLE, CLEAR_ALL, CLEAR_ROW} wr_state_t;

    // Space is blank, 'S' is a real glyph, every other code shows a hollow box
    function automatic logic [7:0] glyph_row(input logic [6:0] code, input logic [3:0] row);
        logic [127:0] bm;
        bm = (code == 7'h20) ? 128'h0 :
             (code == 7'h53) ? 128'h0000_7CC6_C6C0_6038_0C06_C6C6_7C00_0000 :
                               128'h0000_FE82_8282_8282_8282_8282_82FE_0000;
        return bm[{~row, 3'b000} +: 8];
    endfunction
endpackage

// File: rtl/font_rom.sv
// font_rom: 2048x8 glyph ROM addressed by {code[6:0], glyph_row[3:0]}, one clock read latency
module font_rom
    import morse_vga_pkg::*;
(
    input  logic        clk,
    input  logic [10:0] addr,
    output logic [7:0]  data
);
    always_ff @(posedge clk)
        data <= glyph_row(addr[10:4], addr[3:0]);
endmodule

// File: rtl/text_console_renderer.sv
// text_console_renderer: 80x30 character console, 8x16 glyphs to RGB444 with a 2-clk pixel pipeline,
// plus the cursor/wrap/backspace/clear write sequencer that owns the char buffer write port.
module text_console_renderer
    import morse_vga_pkg::*;
#(
    parameter logic [11:0] FG_COLOR    = 12'hFFF,
    parameter logic [11:0] BG_COLOR    = 12'h000,
    parameter bit          SHOW_CURSOR = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    input  logic        clear_req,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row
);
    wr_state_t   state;
    logic [11:0] cnt;
    logic [7:0]  char_buf [BUF_DEPTH];
    logic [7:0]  char_q;
    logic [7:0]  font_q;
    logic [2:0]  x_d1, x_d2;
    logic [3:0]  y_d1;
    logic        von_d1, von_d2, hs_d1, vs_d1, cur_d1, cur_d2;
    logic [11:0] rd_addr, row_base, cur_addr, wr_addr;
    logic [7:0]  wr_data;
    logic        we, accept, printable;
    logic [4:0]  row_next;
    logic        unused_bits;

    assign rd_addr    = 12'(y[8:4]) * 12'(TEXT_COLS) + 12'(x[9:3]);
    assign row_base   = 12'(cursor_row) * 12'(TEXT_COLS);
    assign cur_addr   = row_base + 12'(cursor_col);
    assign printable  = char_data >= CH_SPACE && char_data <= CH_TILDE;
    assign char_ready = state == IDLE && !clear_req;
    assign accept     = char_valid && char_ready;
    assign row_next   = cursor_row == 5'(TEXT_ROWS - 1) ? 5'd0 : cursor_row + 5'd1;
    assign unused_bits = ^{y[9], char_q[7]};

    // Busy states always write; in IDLE only printable codes and an effective backspace touch the buffer
    assign we      = state != IDLE || (accept && (printable || (char_data == CH_BS && cursor_col != 7'd0)));
    assign wr_addr = state == CLEAR_ALL ? cnt :
                     state == CLEAR_ROW ? row_base + cnt :
                     printable          ? cur_addr : cur_addr - 12'd1;
    assign wr_data = state == IDLE && printable ? char_data : CH_SPACE;

    always_ff @(posedge clk) begin
        if (we)
            char_buf[wr_addr] <= wr_data;
        char_q <= char_buf[rd_addr];
    end

    font_rom u_font (
        .clk  (clk),
        .addr ({char_q[6:0], y_d1}),
        .data (font_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {x_d1, x_d2, y_d1} <= '0;
            {von_d1, von_d2, hs_d1, vs_d1, cur_d1, cur_d2, hsync, vsync} <= '0;
        end else begin
            x_d1   <= x[2:0];
            y_d1   <= y[3:0];
            von_d1 <= video_on;
            hs_d1  <= hsync_in;
            vs_d1  <= vsync_in;
            cur_d1 <= SHOW_CURSOR && x[9:3] == cursor_col && y[8:4] == cursor_row && y[3:0] >= 4'd14;
            x_d2   <= x_d1;
            von_d2 <= von_d1;
            cur_d2 <= cur_d1;
            hsync  <= hs_d1;
            vsync  <= vs_d1;
        end
    end

    assign rgb = von_d2 ? ((font_q[~x_d2] || cur_d2) ? FG_COLOR : BG_COLOR) : 12'h000;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= CLEAR_ALL;
            cnt        <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
        end else if (clear_req) begin
            state      <= CLEAR_ALL;
            cnt        <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
        end else begin
            case (state)
                CLEAR_ALL: begin
                    cnt <= cnt == 12'(BUF_DEPTH - 1) ? 12'd0 : cnt + 12'd1;
                    if (cnt == 12'(BUF_DEPTH - 1))
                        state <= IDLE;
                end
                CLEAR_ROW: begin
                    cnt <= cnt == 12'(TEXT_COLS - 1) ? 12'd0 : cnt + 12'd1;
                    if (cnt == 12'(TEXT_COLS - 1))
                        state <= IDLE;
                end
                default: begin
                    if (accept && (char_data == CH_LF || (printable && cursor_col == 7'(TEXT_COLS - 1)))) begin
                        cursor_col <= '0;
                        cursor_row <= row_next;
                        state      <= CLEAR_ROW;
                    end else if (accept && printable) begin
                        cursor_col <= cursor_col + 7'd1;
                    end else if (accept && char_data == CH_BS && cursor_col != 7'd0) begin
                        cursor_col <= cursor_col - 7'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_text_console_renderer.sv
// tb_text_console_renderer: table vectors, hand sequences and a random character stream
// compared against a screen model kept as a plain character array plus cursor.
module tb_text_console_renderer;
    localparam logic [11:0] FG = 12'hFA5;
    localparam logic [11:0] BG = 12'h123;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x, y;
    logic        video_on, hsync_in, vsync_in, char_valid, clear_req;
    logic [7:0]  char_data;
    logic        char_ready, hsync, vsync;
    logic [11:0] rgb;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;

    text_console_renderer #(.FG_COLOR(FG), .BG_COLOR(BG), .SHOW_CURSOR(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .video_on   (video_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .clear_req  (clear_req),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb        (rgb),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mcol = 0;
    int mrow = 0;
    logic [7:0] mbuf [2400];
    logic [7:0] s_rows [16] = '{8'h00, 8'h00, 8'h7C, 8'hC6, 8'hC6, 8'hC0, 8'h60, 8'h38,
                                8'h0C, 8'h06, 8'hC6, 8'hC6, 8'h7C, 8'h00, 8'h00, 8'h00};

    typedef struct {
        logic [9:0]  vx, vy;
        logic        von, hs, vs;
        logic [11:0] exp_rgb;
        logic        exp_hs, exp_vs;
    } vec_t;
    vec_t vt [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    function automatic logic [7:0] tb_glyph(input logic [7:0] ch, input int r);
        if (ch == 8'h20) return 8'h00;
        if (ch == 8'h53) return s_rows[r];
        return (r == 2 || r == 13) ? 8'hFE : (r > 2 && r < 13) ? 8'h82 : 8'h00;
    endfunction

    function automatic logic [11:0] exp_pix(input logic [7:0] ch, input int xr, input int yr, input bit curs);
        logic [7:0] g;
        g = tb_glyph(ch, yr);
        if (curs && yr >= 14) return FG;
        return g[7 - xr] ? FG : BG;
    endfunction

    function automatic void m_clear_all();
        foreach (mbuf[i]) mbuf[i] = 8'h20;
        mcol = 0;
        mrow = 0;
    endfunction

    function automatic void m_new_row();
        mrow = (mrow + 1) % 30;
        for (int c = 0; c < 80; c++) mbuf[mrow * 80 + c] = 8'h20;
    endfunction

    function automatic void m_apply(input logic [7:0] ch);
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            mbuf[mrow * 80 + mcol] = ch;
            if (mcol == 79) begin
                mcol = 0;
                m_new_row();
            end else mcol++;
        end else if (ch == 8'h0A) begin
            mcol = 0;
            m_new_row();
        end else if (ch == 8'h08 && mcol > 0) begin
            mcol--;
            mbuf[mrow * 80 + mcol] = 8'h20;
        end
    endfunction

    task automatic wait_ready(input int want, input string nm);
        int n = 0;
        while (!char_ready && n < 6000) begin
            tick();
            n++;
        end
        chk(nm, n, want);
    endtask

    task automatic send(input logic [7:0] ch);
        int n = 0;
        char_data  = ch;
        char_valid = 1'b1;
        while (!char_ready && n < 6000) begin
            tick();
            n++;
        end
        if (!char_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: char %0h got ready 0 expected 1", ch);
            char_valid = 1'b0;
            return;
        end
        tick();
        char_valid = 1'b0;
        m_apply(ch);
        chk("cursor_col", int'(cursor_col), mcol);
        chk("cursor_row", int'(cursor_row), mrow);
    endtask

    // Streams the 128 pixels of one cell back to back; output i appears two clocks after input i
    task automatic check_cell(input int c, input int r, input string nm);
        logic [11:0] exp_q [$];
        logic [11:0] e, got_first, exp_first;
        int bad = 0;
        for (int i = 0; i <= 128; i++) begin
            if (i < 128) begin
                x = 10'(c * 8 + i % 8);
                y = 10'(r * 16 + i / 8);
                video_on = 1'b1;
                exp_q.push_back(exp_pix(mbuf[r * 80 + c], i % 8, i / 8, c == mcol && r == mrow));
            end else video_on = 1'b0;
            tick();
            if (i >= 1) begin
                e = exp_q.pop_front();
                if (rgb != e) begin
                    if (bad == 0) begin
                        got_first = rgb;
                        exp_first = e;
                    end
                    bad++;
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL cell_%s (%0d,%0d): %0d bad pixels, first got %0h expected %0h",
                     nm, c, r, bad, got_first, exp_first);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; x = '0; y = '0; video_on = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        char_valid = 1'b1; char_data = 8'h41; clear_req = 1'b0;
        repeat (3) tick();
        chk("reset_rgb", int'(rgb), 0);
        chk("reset_hsync", int'(hsync), 0);
        chk("reset_vsync", int'(vsync), 0);
        chk("reset_ready", int'(char_ready), 0);
        chk("reset_cursor", int'({cursor_row, cursor_col}), 0);
        char_valid = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        reset = 1'b1;
        m_clear_all();
        wait_ready(2400, "init_sweep_len");

        // Blank screen, cursor at (0,0): underline, background, gating and sync delay
        vt = '{
            '{10'd0,   10'd14,  1'b1, 1'b1, 1'b0, FG,      1'b1, 1'b0},
            '{10'd0,   10'd13,  1'b1, 1'b0, 1'b1, BG,      1'b0, 1'b1},
            '{10'd7,   10'd15,  1'b1, 1'b1, 1'b1, FG,      1'b1, 1'b1},
            '{10'd8,   10'd15,  1'b1, 1'b0, 1'b0, BG,      1'b0, 1'b0},
            '{10'd3,   10'd14,  1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0},
            '{10'd639, 10'd479, 1'b1, 1'b0, 1'b1, BG,      1'b0, 1'b1},
            '{10'd0,   10'd30,  1'b1, 1'b1, 1'b1, BG,      1'b1, 1'b1},
            '{10'd100, 10'd200, 1'b1, 1'b0, 1'b0, BG,      1'b0, 1'b0},
            '{10'd700, 10'd14,  1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0},
            '{10'd5,   10'd14,  1'b1, 1'b0, 1'b1, FG,      1'b0, 1'b1}
        };
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                x = vt[i].vx; y = vt[i].vy; video_on = vt[i].von;
                hsync_in = vt[i].hs; vsync_in = vt[i].vs;
            end else begin
                video_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
            end
            tick();
            if (i >= 1) begin
                chk($sformatf("vec%0d_rgb", i - 1), int'(rgb), int'(vt[i - 1].exp_rgb));
                chk($sformatf("vec%0d_hsync", i - 1), int'(hsync), int'(vt[i - 1].exp_hs));
                chk($sformatf("vec%0d_vsync", i - 1), int'(vsync), int'(vt[i - 1].exp_vs));
            end
        end

        send(8'h53); send(8'h4F); send(8'h53);
        chk("sos_col", int'(cursor_col), 3);
        check_cell(0, 0, "S");
        check_cell(1, 0, "O");
        check_cell(3, 0, "cursor");

        clear_req = 1'b1; char_valid = 1'b1; char_data = 8'h58;
        #1;
        chk("clear_wins_ready", int'(char_ready), 0);
        tick();
        clear_req = 1'b0; char_valid = 1'b0;
        m_clear_all();
        wait_ready(2400, "clear_sweep_len");
        chk("clear_cursor", int'({cursor_row, cursor_col}), 0);
        check_cell(0, 0, "after_clear");

        for (int i = 0; i < 80; i++) send(8'h45);
        wait_ready(80, "wrap_row_clear_len");
        check_cell(79, 0, "E79");
        check_cell(0, 1, "row1_cursor");

        send(8'h08);
        chk("bs_col0", int'(cursor_col), 0);
        send(8'h54);
        send(8'h08);
        check_cell(0, 1, "bs_blank");

        send(8'h53);
        for (int i = 0; i < 28; i++) send(8'h0A);
        send(8'h53);
        send(8'h0A);
        wait_ready(80, "lf_wrap_clear_len");
        chk("lf_wrap_cursor", int'({cursor_row, cursor_col}), 0);
        check_cell(5, 0, "row0_cleared");
        check_cell(0, 1, "row1_kept");
        check_cell(0, 29, "row29_kept");

        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        m_clear_all();
        repeat (100) tick();
        hsync_in = 1'b1; vsync_in = 1'b1; x = '0; y = '0; video_on = 1'b1;
        repeat (3) tick();
        chk("pre_reset_hsync", int'(hsync), 1);
        chk("pre_reset_rgb", int'(rgb), int'(BG));
        reset = 1'b0;
        #1;
        chk("async_reset_rgb", int'(rgb), 0);
        chk("async_reset_hsync", int'(hsync), 0);
        chk("async_reset_vsync", int'(vsync), 0);
        repeat (2) tick();
        hsync_in = 1'b0; vsync_in = 1'b0; video_on = 1'b0;
        reset = 1'b1;
        wait_ready(2400, "restart_sweep_len");

        for (int i = 0; i < 60; i++) begin
            int r;
            logic [7:0] ch;
            r = $urandom_range(0, 99);
            if (r < 50) ch = 8'($urandom_range(32, 126));
            else if (r < 62) ch = 8'h0A;
            else if (r < 82) ch = 8'h08;
            else begin
                ch = 8'($urandom_range(0, 255));
                while ((ch >= 8'h20 && ch <= 8'h7E) || ch == 8'h0A || ch == 8'h08) ch = 8'($urandom_range(0, 255));
            end
            send(ch);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_ready(0, "rand_settle");
        for (int i = 0; i < 6; i++) check_cell($urandom_range(0, 79), mrow, "rand_row");
        check_cell(mcol, mrow, "rand_cursor");
        for (int i = 0; i < 4; i++) check_cell($urandom_range(0, 79), $urandom_range(0, 29), "rand_any");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
